// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station.
// Holds default geometry (entry count, ROB tag width) and the integer/branch/jump
// opcode encoding carried on disp_op / alu_op. Code 0 means "no operation".
package alu_rs_pkg;

  localparam int RS_SIZE_DEF = 8;   // reservation station entries
  localparam int ROB_W_DEF   = 4;   // ROB tag width
  localparam int OP_W        = 6;   // opcode width

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 6'd0,
    OP_LUI   = 6'd1,
    OP_AUIPC,
    OP_JAL,
    OP_JALR,
    OP_BEQ,
    OP_BNE,
    OP_BLT,
    OP_BGE,
    OP_BLTU,
    OP_BGEU,
    OP_ADDI,
    OP_SLTI,
    OP_SLTIU,
    OP_XORI,
    OP_ORI,
    OP_ANDI,
    OP_SLLI,
    OP_SRLI,
    OP_SRAI,
    OP_ADD,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_SRA,
    OP_OR,
    OP_AND,
    OP_SUB
  } alu_op_e;

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index priority encoder.
// Ports:
//   i_vec   in  N       request vector
//   o_idx   out IDX_W   index of the lowest set bit (0 when none set)
//   o_found out 1       at least one bit of i_vec is set
module rs_pick #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops until both operands are
// present, snooping the ALU and LSB result buses, and issues at most one ready
// op per cycle (lowest index first) into the combinational ALU.
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   rdy_in                  global ready, low freezes the station
//   clear_in                mispredict flush
//   disp_*                  dispatch request, operands/tags, destination tag
//   rs_full                 every entry busy (combinational)
//   cdb_alu_*, cdb_lsb_*    result broadcasts used for wakeup
//   alu_op/rs1/rs2/robid    registered issue to the ALU, alu_op 0 = no issue
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int ROB_W   = ROB_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             disp_valid,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [31:0]      disp_vj,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic             disp_qj_busy,
  input  logic [31:0]      disp_vk,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic             disp_qk_busy,
  input  logic [ROB_W-1:0] disp_robid,
  output logic             rs_full,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_robid,
  input  logic [31:0]      cdb_alu_result,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_robid,
  input  logic [31:0]      cdb_lsb_result,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  output logic [ROB_W-1:0] alu_robid
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry storage
  logic [RS_SIZE-1:0] r_busy;
  logic [RS_SIZE-1:0] r_qj_busy;
  logic [RS_SIZE-1:0] r_qk_busy;
  logic [OP_W-1:0]    r_op    [RS_SIZE];
  logic [31:0]        r_vj    [RS_SIZE];
  logic [31:0]        r_vk    [RS_SIZE];
  logic [ROB_W-1:0]   r_qj    [RS_SIZE];
  logic [ROB_W-1:0]   r_qk    [RS_SIZE];
  logic [ROB_W-1:0]   r_robid [RS_SIZE];

  logic [RS_SIZE-1:0] w_free_vec;
  logic [RS_SIZE-1:0] w_ready_vec;
  logic [IDX_W-1:0]   w_free_idx;
  logic [IDX_W-1:0]   w_ready_idx;
  logic               w_free_found;
  logic               w_ready_found;
  logic               w_disp_fire;
  logic               w_issue_fire;

  // Dispatch operands after same-cycle CDB capture
  logic               w_disp_qj_busy;
  logic               w_disp_qk_busy;
  logic [31:0]        w_disp_vj;
  logic [31:0]        w_disp_vk;

  // Both vectors come from registered state only, so a slot freed by this
  // cycle's issue cannot be reused until the next cycle.
  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_vec
      assign w_free_vec[gi]  = ~r_busy[gi];
      assign w_ready_vec[gi] = r_busy[gi] & ~r_qj_busy[gi] & ~r_qk_busy[gi];
    end
  endgenerate

  rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_free (
    .i_vec   (w_free_vec),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_ready (
    .i_vec   (w_ready_vec),
    .o_idx   (w_ready_idx),
    .o_found (w_ready_found)
  );

  assign rs_full      = ~w_free_found;
  assign w_disp_fire  = disp_valid & ~rs_full & ~clear_in & rdy_in;
  assign w_issue_fire = w_ready_found & ~clear_in & rdy_in;

  // A pending dispatch operand whose producer broadcasts this very cycle is
  // captured directly; the ALU bus takes precedence over the LSB bus.
  always_comb begin
    w_disp_qj_busy = disp_qj_busy;
    w_disp_vj      = disp_vj;
    if (disp_qj_busy && cdb_alu_valid && cdb_alu_robid == disp_qj) begin
      w_disp_qj_busy = 1'b0;
      w_disp_vj      = cdb_alu_result;
    end else if (disp_qj_busy && cdb_lsb_valid && cdb_lsb_robid == disp_qj) begin
      w_disp_qj_busy = 1'b0;
      w_disp_vj      = cdb_lsb_result;
    end

    w_disp_qk_busy = disp_qk_busy;
    w_disp_vk      = disp_vk;
    if (disp_qk_busy && cdb_alu_valid && cdb_alu_robid == disp_qk) begin
      w_disp_qk_busy = 1'b0;
      w_disp_vk      = cdb_alu_result;
    end else if (disp_qk_busy && cdb_lsb_valid && cdb_lsb_robid == disp_qk) begin
      w_disp_qk_busy = 1'b0;
      w_disp_vk      = cdb_lsb_result;
    end
  end

  // Entry state. Wakeup touches only busy entries and dispatch only a
  // non-busy one, so the two never collide on the same slot.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy    <= '0;
      r_qj_busy <= '0;
      r_qk_busy <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]    <= '0;
        r_vj[i]    <= '0;
        r_vk[i]    <= '0;
        r_qj[i]    <= '0;
        r_qk[i]    <= '0;
        r_robid[i] <= '0;
      end
    end else if (clear_in) begin
      r_busy <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && r_qj_busy[i]) begin
          if (cdb_alu_valid && cdb_alu_robid == r_qj[i]) begin
            r_vj[i]      <= cdb_alu_result;
            r_qj_busy[i] <= 1'b0;
          end else if (cdb_lsb_valid && cdb_lsb_robid == r_qj[i]) begin
            r_vj[i]      <= cdb_lsb_result;
            r_qj_busy[i] <= 1'b0;
          end
        end
        if (r_busy[i] && r_qk_busy[i]) begin
          if (cdb_alu_valid && cdb_alu_robid == r_qk[i]) begin
            r_vk[i]      <= cdb_alu_result;
            r_qk_busy[i] <= 1'b0;
          end else if (cdb_lsb_valid && cdb_lsb_robid == r_qk[i]) begin
            r_vk[i]      <= cdb_lsb_result;
            r_qk_busy[i] <= 1'b0;
          end
        end
      end

      if (w_issue_fire) begin
        r_busy[w_ready_idx] <= 1'b0;
      end

      if (w_disp_fire) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_op[w_free_idx]      <= disp_op;
        r_vj[w_free_idx]      <= w_disp_vj;
        r_qj[w_free_idx]      <= disp_qj;
        r_qj_busy[w_free_idx] <= w_disp_qj_busy;
        r_vk[w_free_idx]      <= w_disp_vk;
        r_qk[w_free_idx]      <= disp_qk;
        r_qk_busy[w_free_idx] <= w_disp_qk_busy;
        r_robid[w_free_idx]   <= disp_robid;
      end
    end
  end

  // Issue register. alu_op drops to 0 whenever nothing issues (including
  // flush and freeze) so the ALU never re-broadcasts a stale result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      alu_op    <= '0;
      alu_rs1   <= '0;
      alu_rs2   <= '0;
      alu_robid <= '0;
    end else if (w_issue_fire) begin
      alu_op    <= r_op[w_ready_idx];
      alu_rs1   <= r_vj[w_ready_idx];
      alu_rs2   <= r_vk[w_ready_idx];
      alu_robid <= r_robid[w_ready_idx];
    end else begin
      alu_op <= '0;
    end
  end

endmodule
